// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative 16-bit multiply (shift-add, low half) / unsigned
//             restoring divide for the LC-3 datapath. Start/Done handshake,
//             fixed 16 iterations per operation.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Op_Div,
    input  logic [15:0] A_In,
    input  logic [15:0] B_In,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Result,
    output logic [15:0] Remainder,
    output logic        DivZero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_ITER = 4'd15;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_a;        // latched multiplicand / dividend
    logic [15:0] r_b;        // latched multiplier / divisor
    logic        r_op_div;   // latched operation select
    logic [3:0]  r_cnt;      // iteration index 0..15
    logic [15:0] r_acc;      // product accumulator or quotient shift register
    logic [15:0] r_rem;      // partial remainder (always < divisor between steps)
    logic        r_div_zero;

    logic [15:0] w_addend;
    logic [16:0] w_part;
    logic [16:0] w_diff;
    logic        w_ge;
    logic [15:0] w_rem_next;
    logic        w_unused;

    // Multiply step: shifted multiplicand for this iteration.
    assign w_addend = r_a << r_cnt;

    // Divide step: bring next dividend bit (MSB first) into a 17-bit partial
    // remainder. Since the stored remainder is below the divisor, the
    // post-subtract value always fits back in 16 bits.
    assign w_part     = {r_rem, r_a[c_LAST_ITER - r_cnt]};
    assign w_diff     = w_part - {1'b0, r_b};
    assign w_ge       = (w_part >= {1'b0, r_b});
    assign w_rem_next = w_ge ? w_diff[15:0] : w_part[15:0];
    assign w_unused   = &{1'b0, w_diff[16]};

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                Busy = 1'b1;
                if (r_cnt == c_LAST_ITER) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                Busy         = 1'b1;
                Done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch and per-iteration datapath.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a        <= 16'h0000;
            r_b        <= 16'h0000;
            r_op_div   <= 1'b0;
            r_cnt      <= 4'd0;
            r_acc      <= 16'h0000;
            r_rem      <= 16'h0000;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a        <= A_In;
                        r_b        <= B_In;
                        r_op_div   <= Op_Div;
                        r_cnt      <= 4'd0;
                        r_acc      <= 16'h0000;
                        r_rem      <= 16'h0000;
                        r_div_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_op_div) begin
                        r_acc <= {r_acc[14:0], w_ge};
                        r_rem <= w_rem_next;
                        if ((r_cnt == c_LAST_ITER) && (r_b == 16'h0000)) begin
                            r_div_zero <= 1'b1;
                        end
                    end else if (r_b[r_cnt]) begin
                        r_acc <= r_acc + w_addend;
                    end
                end
                default: begin
                    // DONE: hold results until the next accepted Start.
                end
            endcase
        end
    end

    assign Result    = r_acc;
    assign Remainder = r_rem;
    assign DivZero   = r_div_zero;

endmodule
`default_nettype wire
